// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters over a tagged response channel
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 3,
  parameter bit FAIR  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OP_W-1:0]  req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OP_W-1:0]  req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_v,
  input  logic             alu_n,
  input  logic             alu_z,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_v,
  output logic             resp_n,
  output logic             resp_z
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t r_state, w_next;
  logic r_last, r_id, w_any, w_gnt, w_hs;
  // grant only in IDLE; a tie rotates away from the last winner when FAIR, else requester 0 wins
  always_comb begin
    w_any = req0_valid | req1_valid;
    w_gnt = (req0_valid & req1_valid) ? (FAIR ? ~r_last : 1'b0) : req1_valid;
    w_hs = (r_state == IDLE) & w_any & ~reset;
    req0_ready = w_hs & ~w_gnt;
    req1_ready = w_hs & w_gnt;
    w_next = (r_state == IDLE) ? (w_any ? EXEC : IDLE) :
             (r_state == EXEC) ? RESP : (resp_ready ? IDLE : RESP);
  end
  // latch the winner's operands on handshake, capture the ALU outputs after EXEC, hold until consumed
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_last <= 1'b1;
      r_id <= 1'b0;
      alu_a <= '0;
      alu_b <= '0;
      alu_ctrl <= '0;
      resp_valid <= 1'b0;
      resp_id <= 1'b0;
      resp_result <= '0;
      resp_v <= 1'b0;
      resp_n <= 1'b0;
      resp_z <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_hs) begin
        r_last <= w_gnt;
        r_id <= w_gnt;
        alu_a <= w_gnt ? req1_a : req0_a;
        alu_b <= w_gnt ? req1_b : req0_b;
        alu_ctrl <= w_gnt ? req1_op : req0_op;
      end
      if (r_state == EXEC) begin
        resp_valid <= 1'b1;
        resp_id <= r_id;
        resp_result <= alu_result;
        resp_v <= alu_v;
        resp_n <= alu_n;
        resp_z <= alu_z;
      end
      if (r_state == RESP && resp_ready) resp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of a fair and a fixed-priority alu_arbiter
module tb_alu_arbiter;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic v0 [2], v1 [2], rr [2], rdy0 [2], rdy1 [2], rv [2], rid [2];
  logic alv [2], aln [2], alz [2], rvf [2], rnf [2], rzf [2];
  logic [W-1:0] a0 [2], b0 [2], a1 [2], b1 [2], aa [2], ab [2], ares [2], rres [2];
  logic [2:0] op0 [2], op1 [2], actl [2];
  logic took0 [2], took1 [2];
  bit m_busy [2], m_exec [2], m_id [2], m_last [2], m_ok [2];
  logic [W-1:0] m_a [2], m_b [2];
  logic [2:0] m_op [2];
  logic [34:0] m_resp [2];
  int cmp = 0;
  int bad = 0;

  function automatic logic [34:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    logic [31:0] r;
    logic v;
    v = 1'b0;
    case (op)
      3'd0: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      3'd1: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << b[4:0];
      3'd6: r = a >> b[4:0];
      default: r = {31'b0, $signed(a) < $signed(b)};
    endcase
    return {v, r[31], r == 32'd0, r};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gd
    logic [34:0] w_alu;
    assign w_alu = alu_f(aa[g], ab[g], actl[g]);
    assign ares[g] = w_alu[31:0];
    assign alv[g] = w_alu[34];
    assign aln[g] = w_alu[33];
    assign alz[g] = w_alu[32];
    alu_arbiter #(.WIDTH(W), .OP_W(3), .FAIR(g == 0)) u_dut (
      .clk(clk), .reset(rst),
      .req0_valid(v0[g]), .req0_ready(rdy0[g]), .req0_a(a0[g]), .req0_b(b0[g]), .req0_op(op0[g]),
      .req1_valid(v1[g]), .req1_ready(rdy1[g]), .req1_a(a1[g]), .req1_b(b1[g]), .req1_op(op1[g]),
      .alu_a(aa[g]), .alu_b(ab[g]), .alu_ctrl(actl[g]),
      .alu_result(ares[g]), .alu_v(alv[g]), .alu_n(aln[g]), .alu_z(alz[g]),
      .resp_valid(rv[g]), .resp_ready(rr[g]), .resp_id(rid[g]), .resp_result(rres[g]),
      .resp_v(rvf[g]), .resp_n(rnf[g]), .resp_z(rzf[g]));
  end

  task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, d, act, exp, $time);
    end
  endtask

  // transaction-level reference: idle grant rule, one EXEC cycle, then response held until taken
  always @(negedge clk) begin
    int g;
    for (int d = 0; d < 2; d++) begin
      took0[d] = !rst && v0[d] && rdy0[d];
      took1[d] = !rst && v1[d] && rdy1[d];
      if (rst) begin
        chk("ready0_in_reset", d, rdy0[d], 0);
        chk("ready1_in_reset", d, rdy1[d], 0);
        m_busy[d] = 0; m_exec[d] = 0; m_id[d] = 0; m_last[d] = 1; m_ok[d] = 1;
        m_a[d] = 0; m_b[d] = 0; m_op[d] = 0; m_resp[d] = 0;
      end else if (m_ok[d]) begin
        chk("alu_a", d, aa[d], m_a[d]);
        chk("alu_b", d, ab[d], m_b[d]);
        chk("alu_ctrl", d, actl[d], m_op[d]);
        if (!m_busy[d]) begin
          g = -1;
          if (v0[d] && v1[d]) g = (d == 0) ? (m_last[d] ? 0 : 1) : 0;
          else if (v0[d]) g = 0;
          else if (v1[d]) g = 1;
          chk("ready0", d, rdy0[d], g == 0);
          chk("ready1", d, rdy1[d], g == 1);
          chk("resp_valid_idle", d, rv[d], 0);
          if (g >= 0) begin
            m_busy[d] = 1; m_exec[d] = 1; m_id[d] = g[0]; m_last[d] = g[0];
            m_a[d] = g[0] ? a1[d] : a0[d];
            m_b[d] = g[0] ? b1[d] : b0[d];
            m_op[d] = g[0] ? op1[d] : op0[d];
          end
        end else if (m_exec[d]) begin
          chk("ready0_exec", d, rdy0[d], 0);
          chk("ready1_exec", d, rdy1[d], 0);
          chk("resp_valid_exec", d, rv[d], 0);
          m_resp[d] = alu_f(m_a[d], m_b[d], m_op[d]);
          m_exec[d] = 0;
        end else begin
          chk("ready0_resp", d, rdy0[d], 0);
          chk("ready1_resp", d, rdy1[d], 0);
          chk("resp_valid", d, rv[d], 1);
          chk("resp_id", d, rid[d], m_id[d]);
          chk("resp_result", d, rres[d], m_resp[d][31:0]);
          chk("resp_flags", d, {rvf[d], rnf[d], rzf[d]}, m_resp[d][34:32]);
          if (rr[d]) m_busy[d] = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int d, input int r, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    if (r == 0) begin v0[d] = 1; a0[d] = a; b0[d] = b; op0[d] = op; end
    else begin v1[d] = 1; a1[d] = a; b1[d] = b; op1[d] = op; end
  endtask

  task automatic do_op(input int r, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input logic [31:0] er, input logic [2:0] ef, input string nm);
    int n;
    put(0, r, a, b, op);
    n = 0;
    do begin @(negedge clk); n++; end while (!(r == 1 ? rdy1[0] : rdy0[0]) && n < 20);
    chk({nm, "_accept"}, 0, r == 1 ? rdy1[0] : rdy0[0], 1);
    tick();
    if (r == 1) v1[0] = 0; else v0[0] = 0;
    @(negedge clk);
    chk({nm, "_exec"}, 0, rv[0], 0);
    tick();
    @(negedge clk);
    chk({nm, "_valid"}, 0, rv[0], 1);
    chk({nm, "_id"}, 0, rid[0], r[0]);
    chk({nm, "_result"}, 0, rres[0], er);
    chk({nm, "_vnz"}, 0, {rvf[0], rnf[0], rzf[0]}, ef);
    tick();
  endtask

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h7fffffff;
      2: return 32'h80000000;
      3: return 32'hffffffff;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      v0[d] = 0; v1[d] = 0; rr[d] = 1;
      a0[d] = 0; b0[d] = 0; a1[d] = 0; b1[d] = 0; op0[d] = 0; op1[d] = 0;
    end
    repeat (3) tick();
    rst = 0;
    // tie straight out of reset on the fair instance
    put(0, 0, 1, 2, 3'd0);
    put(0, 1, 124, 73, 3'd4);
    @(negedge clk);
    chk("t3_tie1_r0", 0, rdy0[0], 1);
    chk("t3_tie1_r1", 0, rdy1[0], 0);
    tick(); v0[0] = 0;
    @(negedge clk); tick(); @(negedge clk);
    chk("t3_id0", 0, rid[0], 0);
    chk("t3_res3", 0, rres[0], 3);
    tick(); @(negedge clk);
    chk("t3_r1_ready", 0, rdy1[0], 1);
    tick(); v1[0] = 0;
    @(negedge clk); tick(); @(negedge clk);
    chk("t3_id1", 0, rid[0], 1);
    chk("t3_res53", 0, rres[0], 53);
    tick();
    put(0, 0, 9, 9, 3'd2);
    put(0, 1, 3, 3, 3'd3);
    @(negedge clk);
    chk("t3_tie3_r0", 0, rdy0[0], 1);
    chk("t3_tie3_r1", 0, rdy1[0], 0);
    tick(); v0[0] = 0;
    @(negedge clk); tick(); @(negedge clk); tick(); @(negedge clk);
    chk("t3_tie3_then_r1", 0, rdy1[0], 1);
    tick(); v1[0] = 0;
    @(negedge clk); tick(); @(negedge clk); tick();
    // fixed priority: requester 0 keeps winning while it stays valid
    put(1, 0, 0, 10, 3'd0);
    put(1, 1, 7, 7, 3'd4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_grant_r0", 1, rdy0[1], 1);
      chk("t4_block_r1", 1, rdy1[1], 0);
      tick();
      if (i == 3) v0[1] = 0; else put(1, 0, i + 1, 10, 3'd0);
      @(negedge clk); tick(); @(negedge clk);
      chk("t4_id0", 1, rid[1], 0);
      chk("t4_res", 1, rres[1], i + 10);
      tick();
    end
    @(negedge clk);
    chk("t4_r1_after", 1, rdy1[1], 1);
    tick(); v1[1] = 0;
    @(negedge clk); tick(); @(negedge clk);
    chk("t4_id1", 1, rid[1], 1);
    chk("t4_z", 1, rzf[1], 1);
    tick();
    do_op(0, 124, 73, 3'd0, 197, 3'b000, "t1_add");
    do_op(1, 124, 124, 3'd1, 0, 3'b001, "t2_sub_zero");
    do_op(1, 20, 120, 3'd1, 32'hffffff9c, 3'b010, "t2_sub_neg");
    do_op(0, 32'h7fffffff, 1, 3'd0, 32'h80000000, 3'b110, "overflow_add");
    // backpressure holds the response and blocks new grants
    rr[0] = 0;
    put(0, 0, 5, 6, 3'd0);
    @(negedge clk);
    chk("t5_accept", 0, rdy0[0], 1);
    tick(); v0[0] = 0;
    @(negedge clk); tick(); @(negedge clk);
    chk("t5_valid", 0, rv[0], 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) put(0, 1, 1, 1, 3'd3);
      @(negedge clk);
      chk("t5_hold_valid", 0, rv[0], 1);
      chk("t5_hold_result", 0, rres[0], 11);
      chk("t5_hold_ready1", 0, rdy1[0], 0);
    end
    tick(); rr[0] = 1;
    @(negedge clk);
    chk("t5_release_cycle", 0, rv[0], 1);
    tick(); @(negedge clk);
    chk("t5_done", 0, rv[0], 0);
    chk("t5_next_grant", 0, rdy1[0], 1);
    tick(); v1[0] = 0;
    @(negedge clk); tick(); @(negedge clk);
    chk("t5_next_id", 0, rid[0], 1);
    tick();
    // reset during EXEC drops the operation
    put(0, 0, 32'hffffffff, 1, 3'd7);
    @(negedge clk);
    chk("t6_accept", 0, rdy0[0], 1);
    tick(); v0[0] = 0; rst = 1;
    @(negedge clk);
    tick(); rst = 0;
    @(negedge clk);
    chk("t6_no_resp", 0, rv[0], 0);
    chk("t6_alu_a_cleared", 0, aa[0], 0);
    chk("t6_alu_ctrl_cleared", 0, actl[0], 0);
    for (int i = 0; i < 4; i++) begin
      tick(); @(negedge clk);
      chk("t6_still_no_resp", 0, rv[0], 0);
    end
    // randomized traffic with occasional reset, checked by the reference
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst = ($urandom_range(0, 399) == 0);
      for (int d = 0; d < 2; d++) begin
        rr[d] = $urandom_range(0, 3) != 0;
        if (!v0[d] || took0[d]) begin
          v0[d] = $urandom_range(0, 1) == 1; a0[d] = rnd(); b0[d] = rnd(); op0[d] = 3'($urandom_range(0, 7));
        end
        if (!v1[d] || took1[d]) begin
          v1[d] = $urandom_range(0, 1) == 1; a1[d] = rnd(); b1[d] = rnd(); op1[d] = 3'($urandom_range(0, 7));
        end
      end
    end
    tick(); rst = 0;
    repeat (4) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
